// File: rtl/oport_pkg.sv
// ============================================================================
// oport_pkg : shared tags and width helpers for the output-port capture path
// Rev 1.0
// ============================================================================
`default_nettype none

package oport_pkg;

    localparam logic TAG_DATA = 1'b0;
    localparam logic TAG_HALT = 1'b1;

    function automatic int entry_w(input int port_w);
        return port_w + 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO with show-ahead head read and wrap-bit pointers
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo
    import oport_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [ptr_w(DEPTH):0]    level,
    output logic [WIDTH-1:0]         rd_data
);

    localparam int AW = ptr_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra wrap bit: equal indices with differing wrap bits means full.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign level   = r_wr_ptr - r_rd_ptr;
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= push_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/oport_capture.sv
// ============================================================================
// oport_capture : records output-port changes and halt markers into a FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module oport_capture
    import oport_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PORT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PORT_W-1:0]        oport,
    input  logic                     c_halt,
    output logic [PORT_W:0]          out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ptr_w(DEPTH):0]    level,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int EW = entry_w(PORT_W);

    logic [PORT_W-1:0] r_last_port;
    logic              r_halt_q;
    logic              r_halt_pend;
    logic              r_overflow;
    logic [7:0]        r_drop_count;

    logic              w_data_ev;
    logic              w_halt_ev;
    logic              w_from_pend;
    logic              w_push;
    logic [EW-1:0]     w_push_data;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_rejected;
    logic              w_drop;

    assign w_data_ev   = (oport != r_last_port);
    assign w_halt_ev   = c_halt & ~r_halt_q;
    assign w_from_pend = ~w_data_ev & r_halt_pend;

    assign w_push      = w_data_ev | r_halt_pend | w_halt_ev;
    assign w_push_data = w_data_ev ? {TAG_DATA, oport} : {TAG_HALT, r_last_port};

    assign w_pop       = out_valid & out_ready;
    assign w_rejected  = w_full & ~w_pop;
    // A deferred marker is retried rather than lost, so it never counts as a drop.
    assign w_drop      = w_push & w_rejected & ~w_from_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_port  <= '0;
            r_halt_q     <= 1'b0;
            r_halt_pend  <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_last_port <= oport;
            r_halt_q    <= c_halt;

            if (w_data_ev) begin
                r_halt_pend <= r_halt_pend | w_halt_ev;
            end else if (w_from_pend) begin
                r_halt_pend <= w_rejected;
            end else begin
                r_halt_pend <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .level     (level),
        .rd_data   (out_data)
    );

    assign out_valid  = ~w_empty;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

`default_nettype wire

// File: doc/oport_capture.md
Name: oport_capture

Overview:
- Consumer side of the computer's 8-bit output port: watches `oport` and `c_halt` and records every change of `oport` as a timestamped-free event entry.
- Buffers entries in a FIFO and drains them to a host or bench through a valid/ready stream.
- Sits beside `computer` at top level; replaces ad-hoc `$display` monitoring with a synthesizable capture path.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- PORT_W, 8, width of the observed output port.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- oport  in  PORT_W  computer output port, sampled each rising edge.
- c_halt  in  1  computer halt flag, sampled each rising edge.
- out_data  out  PORT_W+1  head entry; bit PORT_W = tag (0 data, 1 halt marker), low bits = value.
- out_valid  out  1  head entry valid.
- out_ready  in  1  host accepts the head entry when out_valid & out_ready at a rising edge.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when any entry was dropped.
- drop_count  out  8  dropped entries, saturates at 255.

Behaviour:
- Reset (asynchronous assert, applies immediately, including mid-operation):
  - Clears `last_port` to 0, `halt_q` to 0, `halt_pend` to 0.
  - FIFO pointers to 0, `level` = 0, `out_valid` = 0, `out_data` = 0.
  - `overflow` = 0, `drop_count` = 0.
- Event detection, per edge:
  - `data_ev` = (oport != last_port); `last_port` <= oport every edge.
  - `halt_ev` = c_halt & ~halt_q; `halt_q` <= c_halt. Only the rising edge of `c_halt` creates an event.
- Push arbitration (at most one push per edge):
  - If `data_ev`: push {0, oport}.
  - Else if `halt_pend` or `halt_ev`: push {1, last_port} and clear `halt_pend`.
  - If `data_ev` & `halt_ev` in the same cycle: the data entry is pushed; `halt_pend` is set; the marker is pushed on the next edge, ahead of any new data event. While `halt_pend` is set, a data event still wins and the marker waits.
- Latency: a change present before edge N is pushed at edge N; `out_valid`/`out_data` reflect it after edge N (1 cycle).
- Pop: at an edge where out_valid & out_ready, the head is removed. `out_data` is stable while out_valid & ~out_ready.
- Full:
  - Push while full and no pop at the same edge → entry dropped; `overflow` <= 1; `drop_count` increments, saturating at 255.
  - Push and pop at the same edge while full → both accepted; `level` is unchanged.
- Empty:
  - Pop is impossible because out_valid = 0.
  - Push into empty FIFO → out_valid = 1 after that edge; no bypass of the register stage.
- Pointers wrap modulo DEPTH. An extra wrap bit distinguishes full (level = DEPTH) from empty.
- Dropped halt markers are counted as drops; a halt marker held in `halt_pend` is never dropped.
- `level` = pushes − pops. It updates on the same edge as the push or pop.

Decomposition:
- Shared package `oport_pkg` holds:
  - TAG_DATA = 1'b0 and TAG_HALT = 1'b1.
  - Entry width function PORT_W+1.
  - Pointer width function $clog2(DEPTH).
- Sub-module `sync_fifo` (params WIDTH, DEPTH):
  - Interface: push/pop, full/empty/level, registered read data.
  - `oport_capture` instantiates one `sync_fifo` and holds the edge detection, arbitration, `halt_pend` and drop logic.

Test Plan:
1. Reset, then oport held 8'h00 for 20 cycles → out_valid stays 0, level 0. Then oport = 8'h5A for 1 cycle and 8'h5A held → exactly one entry 9'h05A, valid one cycle after the edge.
2. out_ready = 1, oport sequence 8'h01, 8'h02, 8'h03 on consecutive edges → out_data 9'h001, 9'h002, 9'h003 in order; level never exceeds 1.
3. oport 8'h10 → 8'h11 with c_halt 0→1 at the same edge → entries 9'h011 then 9'h111 on consecutive edges. Holding c_halt high produces no further markers.
4. out_ready = 0, DEPTH = 16, 18 distinct oport changes → level 16, overflow 1, drop_count 2. First 16 values drain in order once out_ready = 1.
5. FIFO full, out_ready = 1, a new change on the same edge → push accepted; level stays 16; drop_count unchanged.
6. Assert reset asynchronously mid-burst with level 5 → out_valid, level, overflow and drop_count are 0 immediately, before the next clock edge. After release, oport = 8'h00 creates no entry.
